// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the AW master slice.
// Protection encodings, AW FSM states and the queued request bundle.
package axi_lite_pkg;

   localparam int AXI_PROT_W = 3;
   localparam int AXI_ADDR_W = 32;

   localparam logic [AXI_PROT_W-1:0] PROT_PRIV  = 3'b001;
   localparam logic [AXI_PROT_W-1:0] PROT_NSEC  = 3'b010;
   localparam logic [AXI_PROT_W-1:0] PROT_INSTR = 3'b100;

   typedef enum logic {
      AW_IDLE,
      AW_SEND
   } aw_state_t;

   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [AXI_PROT_W-1:0] prot;
   } aw_req_t;

endpackage

// File: rtl/axi_lite_sync_fifo.sv
// Synchronous FIFO with flop storage; the head word is read straight from
// the storage registers so a pop at an edge captures it with no extra cycle.
// Ports: clk, rst (sync, active-high), push/wr_data, pop/rd_data,
//        full, empty, level (0..DEPTH).
module axi_lite_sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

   // A push at full is legal only when a pop frees the slot this cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/axi_lite_aw_master_q.sv
// AXI4-Lite AW master: queues {addr,prot} requests in a FIFO and issues them
// on AW with at most MAX_OUTST writes awaiting b_done.
// Ports: ACLK, ARESET (sync, active-high); req_valid/req_ready/req_addr/
//   req_prot request side; AWVALID/AWREADY/AWADDR/AWPROT AXI side; b_done
//   completion pulse; outst_cnt, q_level, idle status.
// Optional AW_ALIGN_CHK_EN: adds align_err, drops misaligned requests.
module axi_lite_aw_master_q #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int MAX_OUTST  = 2,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_prot,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [2:0]            AWPROT,
   input  logic                  b_done,
   output logic [3:0]            outst_cnt,
   output logic [LW-1:0]         q_level,
   output logic                  idle
`ifdef AW_ALIGN_CHK_EN
   ,
   output logic                  align_err
`endif
);

   import axi_lite_pkg::*;

   localparam int FW = ADDR_WIDTH + AXI_PROT_W;
   localparam logic [4:0] MAX5 = 5'(MAX_OUTST);

   aw_state_t         state;
   aw_state_t         state_nxt;
   logic              accept;
   logic              push;
   logic              pop;
   logic [FW-1:0]     fifo_rd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              hs;
   logic              b_dec;
   logic [3:0]        outst_after_b;
   logic              room_now;
   logic              room_next;

   assign req_ready = ~fifo_full;
   assign accept    = req_valid & req_ready;

`ifdef AW_ALIGN_CHK_EN
   logic misaligned;
   assign misaligned = (req_addr[1:0] != 2'b00);
   assign push       = accept & ~misaligned;

   always_ff @(posedge ACLK) begin
      if (ARESET) align_err <= 1'b0;
      else        align_err <= accept & misaligned;
   end
`else
   assign push = accept;
`endif

   axi_lite_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (ACLK),
      .rst     (ARESET),
      .push    (push),
      .wr_data ({req_addr, req_prot}),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (q_level)
   );

   assign AWVALID = (state == AW_SEND);
   assign hs      = AWVALID & AWREADY;

   // b_done with nothing outstanding is ignored.
   assign b_dec         = b_done & (outst_cnt != 4'd0);
   assign outst_after_b = outst_cnt - {3'b000, b_dec};

   // 5-bit compares so MAX_OUTST=15 cannot wrap.
   assign room_now  = ({1'b0, outst_cnt} < MAX5);
   assign room_next = (({1'b0, outst_after_b} + 5'd1) < MAX5);

   always_ff @(posedge ACLK) begin
      if (ARESET) state <= AW_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         AW_IDLE: begin
            if (!fifo_empty && room_now) begin
               pop       = 1'b1;
               state_nxt = AW_SEND;
            end
         end
         AW_SEND: begin
            // Back-to-back issue counts the handshake completing now.
            if (AWREADY) begin
               if (!fifo_empty && room_next) pop = 1'b1;
               else                          state_nxt = AW_IDLE;
            end
         end
         default: state_nxt = AW_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         AWADDR <= '0;
         AWPROT <= '0;
      end else if (pop) begin
         {AWADDR, AWPROT} <= fifo_rd;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         outst_cnt <= 4'd0;
      end else begin
         unique case ({hs, b_dec})
            2'b10:   outst_cnt <= outst_cnt + 4'd1;
            2'b01:   outst_cnt <= outst_cnt - 4'd1;
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

   assign idle = fifo_empty & ~AWVALID & (outst_cnt == 4'd0);

endmodule

// File: tb/tb_axi_lite_aw_master_q.sv
// Scoreboard bench for axi_lite_aw_master_q (default parameters).
// Expected AW beats are queued at request time and checked by a monitor.
module tb_axi_lite_aw_master_q;

   import axi_lite_pkg::*;

   logic        ACLK;
   logic        ARESET;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_prot;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        b_done;
   logic [3:0]  outst_cnt;
   logic [2:0]  q_level;
   logic        idle;
`ifdef AW_ALIGN_CHK_EN
   logic        align_err;
`endif

   int passed;
   int total;
   aw_req_t exp_q[$];

   axi_lite_aw_master_q dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_prot  (req_prot),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .AWADDR    (AWADDR),
      .AWPROT    (AWPROT),
      .b_done    (b_done),
      .outst_cnt (outst_cnt),
      .q_level   (q_level),
      .idle      (idle)
`ifdef AW_ALIGN_CHK_EN
      ,
      .align_err (align_err)
`endif
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every AW handshake must match the head of the scoreboard.
   always @(negedge ACLK) begin
      if (!ARESET && AWVALID && AWREADY) begin
         if (exp_q.size() == 0) begin
            check("aw_unexpected", {32'd0, AWADDR}, 64'hDEAD);
         end else begin
            aw_req_t e;
            e = exp_q.pop_front();
            check("aw_addr", {32'd0, AWADDR}, {32'd0, e.addr});
            check("aw_prot", {61'd0, AWPROT}, {61'd0, e.prot});
         end
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [2:0] p,
                       input bit queued);
      check("req_ready_before_push", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_prot  = p;
      if (queued) exp_q.push_back('{addr: a, prot: p});
      tick();
      req_valid = 1'b0;
   endtask

   task automatic pulse_b();
      b_done = 1'b1;
      tick();
      b_done = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!idle && n < budget) begin
         tick();
         n++;
      end
      check("idle_within_budget", {63'd0, idle}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      passed    = 0;
      total     = 0;
      ARESET    = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0000_1234;
      req_prot  = 3'b000;
      AWREADY   = 1'b0;
      b_done    = 1'b0;

      // Reset held with a live request
      tick();
      tick();
      check("rst_awvalid", {63'd0, AWVALID}, 64'd0);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_idle", {63'd0, idle}, 64'd1);
      check("rst_q_level", {61'd0, q_level}, 64'd0);
      check("rst_outst", {60'd0, outst_cnt}, 64'd0);
      check("rst_awaddr", {32'd0, AWADDR}, 64'd0);
      req_valid = 1'b0;
      ARESET    = 1'b0;
      tick();

      // Single write, slave always ready
      AWREADY = 1'b1;
      push(32'hFFFF_FFFC, PROT_NSEC, 1'b1);
      check("t2_no_bypass", {63'd0, AWVALID}, 64'd0);
      tick();
      check("t2_awvalid_hi", {63'd0, AWVALID}, 64'd1);
      tick();
      check("t2_awvalid_lo", {63'd0, AWVALID}, 64'd0);
      check("t2_outst_1", {60'd0, outst_cnt}, 64'd1);
      pulse_b();
      check("t2_outst_0", {60'd0, outst_cnt}, 64'd0);
      check("t2_idle", {63'd0, idle}, 64'd1);

      // b_done with nothing outstanding saturates at 0
      pulse_b();
      check("b_sat_outst", {60'd0, outst_cnt}, 64'd0);

      // Backpressure: 3 cycles not ready, handshake on the 4th
      AWREADY = 1'b0;
      push(32'h0000_0010, PROT_PRIV, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) AWREADY = 1'b1;
         check("t3_awvalid_stable", {63'd0, AWVALID}, 64'd1);
         check("t3_awaddr_stable", {32'd0, AWADDR}, 64'h10);
         tick();
      end
      AWREADY = 1'b0;
      check("t3_awvalid_lo", {63'd0, AWVALID}, 64'd0);
      check("t3_outst_1", {60'd0, outst_cnt}, 64'd1);
      pulse_b();
      check("t3_outst_0", {60'd0, outst_cnt}, 64'd0);

      // Fill the FIFO behind a stalled AW, then drain in order
      for (int i = 0; i < 4; i++)
         push(32'(i * 4), 3'(i), 1'b1);
      check("t4_q_level_3", {61'd0, q_level}, 64'd3);
      check("t4_head_addr", {32'd0, AWADDR}, 64'h0);
      push(32'h0000_0010, PROT_INSTR, 1'b1);
      check("t4_q_level_4", {61'd0, q_level}, 64'd4);
      check("t4_req_ready_full", {63'd0, req_ready}, 64'd0);
      AWREADY = 1'b1;
      b_done  = 1'b1;
      wait_idle(20);
      b_done  = 1'b0;
      AWREADY = 1'b0;
      check("t4_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      // Outstanding limit of 2
      push(32'h0000_0020, 3'b000, 1'b1);
      push(32'h0000_0024, 3'b000, 1'b1);
      push(32'h0000_0028, 3'b000, 1'b1);
      AWREADY = 1'b1;
      repeat (4) tick();
      check("t5_awvalid_blocked", {63'd0, AWVALID}, 64'd0);
      check("t5_outst_2", {60'd0, outst_cnt}, 64'd2);
      check("t5_q_level_1", {61'd0, q_level}, 64'd1);
      pulse_b();
      check("t5_outst_after_b", {60'd0, outst_cnt}, 64'd1);
      check("t5_awvalid_still_lo", {63'd0, AWVALID}, 64'd0);
      tick();
      check("t5_third_issued", {63'd0, AWVALID}, 64'd1);
      check("t5_third_addr", {32'd0, AWADDR}, 64'h28);
      tick();
      check("t5_outst_2_again", {60'd0, outst_cnt}, 64'd2);

      // Handshake and b_done in the same cycle
      pulse_b();
      check("t6_outst_1", {60'd0, outst_cnt}, 64'd1);
      push(32'h0000_0030, PROT_PRIV, 1'b1);
      tick();
      check("t6_awvalid", {63'd0, AWVALID}, 64'd1);
      b_done = 1'b1;
      tick();
      b_done = 1'b0;
      check("t6_outst_same", {60'd0, outst_cnt}, 64'd1);
      pulse_b();
      check("t6_idle", {63'd0, idle}, 64'd1);

      // Misaligned address
      AWREADY = 1'b1;
`ifdef AW_ALIGN_CHK_EN
      push(32'h0000_0006, 3'b000, 1'b0);
      check("al_err_hi", {63'd0, align_err}, 64'd1);
      check("al_not_queued", {61'd0, q_level}, 64'd0);
      tick();
      check("al_err_lo", {63'd0, align_err}, 64'd0);
      check("al_idle", {63'd0, idle}, 64'd1);
`else
      push(32'h0000_0006, PROT_PRIV, 1'b1);
      b_done = 1'b1;
      wait_idle(10);
      b_done = 1'b0;
      check("al_scoreboard_empty", 64'(exp_q.size()), 64'd0);
`endif

      // Reset in the middle of a stalled burst
      AWREADY = 1'b0;
      push(32'h0000_0040, 3'b000, 1'b1);
      push(32'h0000_0044, 3'b000, 1'b1);
      push(32'h0000_0048, 3'b000, 1'b1);
      check("mr_awvalid_pre", {63'd0, AWVALID}, 64'd1);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      exp_q.delete();
      check("mr_awvalid", {63'd0, AWVALID}, 64'd0);
      check("mr_q_level", {61'd0, q_level}, 64'd0);
      check("mr_idle", {63'd0, idle}, 64'd1);
      AWREADY = 1'b1;
      tick();
      check("mr_awvalid_after", {63'd0, AWVALID}, 64'd0);
      check("mr_outst", {60'd0, outst_cnt}, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
